// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the F-stage PC, talks to a variable-latency
// instruction memory, buffers a word while D is stalled and drives IF/ID.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] NPC,
  input  logic        stall_D,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] PC,
  output logic [31:0] PC_D,
  output logic [31:0] Instr_D,
  output logic        valid_D,
  output logic        adel_D,
  output logic        fetch_stall
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] buf_data_r;
  logic        buf_adel_r;
  logic [31:0] pc_d_r;
  logic [31:0] instr_d_r;
  logic        valid_d_r;
  logic        adel_d_r;

  logic        misaligned_s;
  logic        avail_s;
  logic [31:0] data_s;
  logic        adel_s;
  logic        advance_s;
  logic        capture_s;

  // Select the instruction source for this cycle and decide advance/capture
  always_comb begin
    misaligned_s = (pc_r[1:0] != 2'b00);
    avail_s      = 1'b0;
    data_s       = NOP_WORD;
    adel_s       = 1'b0;
    case (state_r)
      ST_FETCH: begin
        // A misaligned PC never reaches memory; a NOP tagged adel stands in.
        if (misaligned_s) begin
          avail_s = 1'b1;
          data_s  = NOP_WORD;
          adel_s  = 1'b1;
        end else begin
          avail_s = im_ack;
          data_s  = im_rdata;
          adel_s  = 1'b0;
        end
      end
      ST_READY: begin
        avail_s = 1'b1;
        data_s  = buf_data_r;
        adel_s  = buf_adel_r;
      end
      default: begin
        avail_s = 1'b0;
        data_s  = NOP_WORD;
        adel_s  = 1'b0;
      end
    endcase
    advance_s = avail_s & ~stall_D;
    capture_s = (state_r == ST_FETCH) & avail_s & stall_D;
  end

  assign im_req      = (state_r == ST_FETCH) & ~misaligned_s;
  assign im_addr     = pc_r;
  assign fetch_stall = ~avail_s;
  assign PC          = pc_r;
  assign PC_D        = pc_d_r;
  assign Instr_D     = instr_d_r;
  assign valid_D     = valid_d_r;
  assign adel_D      = adel_d_r;

  // Fetch FSM, PC, skid buffer and IF/ID register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_FETCH;
      pc_r       <= RESET_PC;
      buf_data_r <= 32'h0000_0000;
      buf_adel_r <= 1'b0;
      pc_d_r     <= 32'h0000_0000;
      instr_d_r  <= 32'h0000_0000;
      valid_d_r  <= 1'b0;
      adel_d_r   <= 1'b0;
    end else if (advance_s) begin
      pc_d_r    <= pc_r;
      instr_d_r <= data_s;
      adel_d_r  <= adel_s;
      valid_d_r <= 1'b1;
      pc_r      <= NPC;
      state_r   <= ST_FETCH;
    end else if (capture_s) begin
      // D is stalled: park the word so the memory transaction can retire.
      buf_data_r <= data_s;
      buf_adel_r <= adel_s;
      state_r    <= ST_READY;
    end else begin
      state_r <= state_r;
      pc_r    <= pc_r;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: table of per-cycle vectors plus
// hand-written reset sequences; post-edge expectations go through a queue.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic [31:0] NPC;
  logic        stall_D;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] PC;
  logic [31:0] PC_D;
  logic [31:0] Instr_D;
  logic        valid_D;
  logic        adel_D;
  logic        fetch_stall;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] npc;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fstall;
    logic [31:0] e_pc;
    logic [31:0] e_pcd;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_adel;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcd;
    logic [31:0] instr;
    logic        valid;
    logic        adel;
  } post_t;

  post_t sb_q[$];
  vec_t  vecs[22];

  if_fetch_stage #(
    .RESET_PC(32'h0000_3000),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .NPC(NPC),
    .stall_D(stall_D),
    .im_req(im_req),
    .im_addr(im_addr),
    .im_ack(im_ack),
    .im_rdata(im_rdata),
    .PC(PC),
    .PC_D(PC_D),
    .Instr_D(Instr_D),
    .valid_D(valid_D),
    .adel_D(adel_D),
    .fetch_stall(fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] npc, input logic stall, input logic ack,
                              input logic [31:0] rdata, input logic e_req,
                              input logic [31:0] e_addr, input logic e_fstall,
                              input logic [31:0] e_pc, input logic [31:0] e_pcd,
                              input logic [31:0] e_instr, input logic e_valid,
                              input logic e_adel);
    vec_t v;
    v.npc = npc; v.stall = stall; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_fstall = e_fstall;
    v.e_pc = e_pc; v.e_pcd = e_pcd; v.e_instr = e_instr;
    v.e_valid = e_valid; v.e_adel = e_adel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check combinational outputs, queue the post-edge state.
  task automatic apply(input vec_t v, input string tag);
    post_t p;
    NPC      = v.npc;
    stall_D  = v.stall;
    im_ack   = v.ack;
    im_rdata = v.rdata;
    #2;
    chk({tag, ".im_req"}, {31'd0, im_req}, {31'd0, v.e_req});
    chk({tag, ".im_addr"}, im_addr, v.e_addr);
    chk({tag, ".fetch_stall"}, {31'd0, fetch_stall}, {31'd0, v.e_fstall});
    p.pc = v.e_pc; p.pcd = v.e_pcd; p.instr = v.e_instr;
    p.valid = v.e_valid; p.adel = v.e_adel;
    sb_q.push_back(p);
    @(posedge clk);
    #1;
    p = sb_q.pop_front();
    chk({tag, ".PC"}, PC, p.pc);
    chk({tag, ".PC_D"}, PC_D, p.pcd);
    chk({tag, ".Instr_D"}, Instr_D, p.instr);
    chk({tag, ".valid_D"}, {31'd0, valid_D}, {31'd0, p.valid});
    chk({tag, ".adel_D"}, {31'd0, adel_D}, {31'd0, p.adel});
  endtask

  task automatic rst_check(input string tag);
    chk({tag, ".PC"}, PC, 32'h0000_3000);
    chk({tag, ".im_addr"}, im_addr, 32'h0000_3000);
    chk({tag, ".PC_D"}, PC_D, 32'h0000_0000);
    chk({tag, ".Instr_D"}, Instr_D, 32'h0000_0000);
    chk({tag, ".valid_D"}, {31'd0, valid_D}, 32'h0000_0000);
    chk({tag, ".adel_D"}, {31'd0, adel_D}, 32'h0000_0000);
  endtask

  initial begin
    // zero-latency stream
    vecs[0]  = mk(32'h0000_3004, 1'b0, 1'b1, 32'h8c01_0000, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_3004, 32'h0000_3000, 32'h8c01_0000, 1'b1, 1'b0);
    vecs[1]  = mk(32'h0000_3008, 1'b0, 1'b1, 32'h8c01_0004, 1'b1, 32'h0000_3004, 1'b0, 32'h0000_3008, 32'h0000_3004, 32'h8c01_0004, 1'b1, 1'b0);
    vecs[2]  = mk(32'h0000_300c, 1'b0, 1'b1, 32'h8c01_0008, 1'b1, 32'h0000_3008, 1'b0, 32'h0000_300c, 32'h0000_3008, 32'h8c01_0008, 1'b1, 1'b0);
    // 3-cycle memory latency
    vecs[3]  = mk(32'h0000_3010, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_300c, 1'b1, 32'h0000_300c, 32'h0000_3008, 32'h8c01_0008, 1'b1, 1'b0);
    vecs[4]  = mk(32'h0000_3010, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_300c, 1'b1, 32'h0000_300c, 32'h0000_3008, 32'h8c01_0008, 1'b1, 1'b0);
    vecs[5]  = mk(32'h0000_3010, 1'b0, 1'b1, 32'h2010_0001, 1'b1, 32'h0000_300c, 1'b0, 32'h0000_3010, 32'h0000_300c, 32'h2010_0001, 1'b1, 1'b0);
    // ack under stall_D, buffered for two more cycles (stray ack ignored)
    vecs[6]  = mk(32'h0000_3014, 1'b1, 1'b1, 32'h2408_0005, 1'b1, 32'h0000_3010, 1'b0, 32'h0000_3010, 32'h0000_300c, 32'h2010_0001, 1'b1, 1'b0);
    vecs[7]  = mk(32'h0000_3014, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_3010, 1'b0, 32'h0000_3010, 32'h0000_300c, 32'h2010_0001, 1'b1, 1'b0);
    vecs[8]  = mk(32'h0000_3014, 1'b1, 1'b1, 32'hdead_beef, 1'b0, 32'h0000_3010, 1'b0, 32'h0000_3010, 32'h0000_300c, 32'h2010_0001, 1'b1, 1'b0);
    vecs[9]  = mk(32'h0000_3014, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_3010, 1'b0, 32'h0000_3014, 32'h0000_3010, 32'h2408_0005, 1'b1, 1'b0);
    // branch in D, slow delay-slot fetch, NPC junk while waiting
    vecs[10] = mk(32'h0000_3018, 1'b0, 1'b1, 32'h1000_0010, 1'b1, 32'h0000_3014, 1'b0, 32'h0000_3018, 32'h0000_3014, 32'h1000_0010, 1'b1, 1'b0);
    vecs[11] = mk(32'h7777_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3018, 1'b1, 32'h0000_3018, 32'h0000_3014, 32'h1000_0010, 1'b1, 1'b0);
    vecs[12] = mk(32'h0000_4000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3018, 1'b1, 32'h0000_3018, 32'h0000_3014, 32'h1000_0010, 1'b1, 1'b0);
    vecs[13] = mk(32'h0000_4000, 1'b0, 1'b1, 32'h3c01_0001, 1'b1, 32'h0000_3018, 1'b0, 32'h0000_4000, 32'h0000_3018, 32'h3c01_0001, 1'b1, 1'b0);
    // misaligned PC, then misaligned under stall_D
    vecs[14] = mk(32'h0000_3002, 1'b0, 1'b1, 32'h0274_1020, 1'b1, 32'h0000_4000, 1'b0, 32'h0000_3002, 32'h0000_4000, 32'h0274_1020, 1'b1, 1'b0);
    vecs[15] = mk(32'h0000_3008, 1'b0, 1'b1, 32'hffff_ffff, 1'b0, 32'h0000_3002, 1'b0, 32'h0000_3008, 32'h0000_3002, 32'h0000_0000, 1'b1, 1'b1);
    vecs[16] = mk(32'h0000_300e, 1'b0, 1'b1, 32'habcd_0001, 1'b1, 32'h0000_3008, 1'b0, 32'h0000_300e, 32'h0000_3008, 32'habcd_0001, 1'b1, 1'b0);
    vecs[17] = mk(32'h0000_3010, 1'b1, 1'b1, 32'hffff_ffff, 1'b0, 32'h0000_300e, 1'b0, 32'h0000_300e, 32'h0000_3008, 32'habcd_0001, 1'b1, 1'b0);
    vecs[18] = mk(32'h0000_3010, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_300e, 1'b0, 32'h0000_3010, 32'h0000_300e, 32'h0000_0000, 1'b1, 1'b1);
    // wrap at 2^32, then wait with both stalls
    vecs[19] = mk(32'hffff_fffc, 1'b0, 1'b1, 32'h0000_0011, 1'b1, 32'h0000_3010, 1'b0, 32'hffff_fffc, 32'h0000_3010, 32'h0000_0011, 1'b1, 1'b0);
    vecs[20] = mk(32'h0000_0000, 1'b0, 1'b1, 32'h0000_0022, 1'b1, 32'hffff_fffc, 1'b0, 32'h0000_0000, 32'hffff_fffc, 32'h0000_0022, 1'b1, 1'b0);
    vecs[21] = mk(32'h0000_0004, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'hffff_fffc, 32'h0000_0022, 1'b1, 1'b0);

    reset_n  = 1'b0;
    NPC      = 32'h0000_0000;
    stall_D  = 1'b0;
    im_ack   = 1'b0;
    im_rdata = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    rst_check("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // reset while waiting on memory: clears without a clock edge
    im_ack  = 1'b0;
    reset_n = 1'b0;
    #1;
    rst_check("rst_wait");
    #1;
    reset_n = 1'b1;
    apply(mk(32'h0000_3004, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0), "lat0");
    apply(mk(32'h0000_3004, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0), "lat1");
    apply(mk(32'h0000_3004, 1'b0, 1'b1, 32'h8000_0001, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_3004, 32'h0000_3000, 32'h8000_0001, 1'b1, 1'b0), "lat2");
    apply(mk(32'h0000_3008, 1'b1, 1'b1, 32'h5555_aaaa, 1'b1, 32'h0000_3004, 1'b0, 32'h0000_3004, 32'h0000_3000, 32'h8000_0001, 1'b1, 1'b0), "rdy");

    // reset while a word sits in the buffer: it must be lost
    im_ack  = 1'b0;
    reset_n = 1'b0;
    #1;
    rst_check("rst_ready");
    #1;
    reset_n = 1'b1;
    apply(mk(32'h0000_3004, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0), "post0");
    apply(mk(32'h0000_3004, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_3004, 32'h0000_3000, 32'h1234_5678, 1'b1, 1'b0), "post1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
